// File: rtl/idct_pkg.sv
// idct_pkg: shared widths, block type and the round/saturate helper for the IDCT output stage
package idct_pkg;
    localparam int DW = 25;
    localparam int OW = 9;
    localparam int SHIFT = 12;
    localparam logic signed [DW:0] RND = (DW+1)'(1) << (SHIFT-1);
    localparam logic signed [DW:0] SAT_HI = (DW+1)'((1 << (OW-1)) - 1);
    localparam logic signed [DW:0] SAT_LO = ~SAT_HI;

    // indexed [row][col]
    typedef logic [3:0][3:0][OW-1:0] block_t;

    // one extra bit of headroom keeps the rounding add from wrapping
    function automatic logic signed [OW-1:0] round_sat(input logic signed [DW-1:0] x);
        logic signed [DW:0] y;
        y = ($signed({x[DW-1], x}) + RND) >>> SHIFT;
        return (y > SAT_HI) ? SAT_HI[OW-1:0] : (y < SAT_LO) ? SAT_LO[OW-1:0] : y[OW-1:0];
    endfunction
endpackage

// File: rtl/idct_deskew.sv
// idct_deskew: realigns the four skewed column lanes (delays 3/2/1/0) and the column valid (delay 3)
module idct_deskew #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] d_in_1,
    input  logic [W-1:0] d_in_2,
    input  logic [W-1:0] d_in_3,
    input  logic [W-1:0] d_in_4,
    output logic         col_valid,
    output logic [W-1:0] col_1,
    output logic [W-1:0] col_2,
    output logic [W-1:0] col_3,
    output logic [W-1:0] col_4
);
    logic [2:0]   vq;
    logic [W-1:0] l1 [3];
    logic [W-1:0] l2 [2];
    logic [W-1:0] l3;

    always_ff @(posedge clk) begin
        if (reset) vq <= '0;
        else vq <= {vq[1:0], in_valid};
    end

    always_ff @(posedge clk) begin
        l1[0] <= d_in_1;
        l1[1] <= l1[0];
        l1[2] <= l1[1];
        l2[0] <= d_in_2;
        l2[1] <= l2[0];
        l3 <= d_in_3;
    end

    assign col_valid = vq[2];
    assign col_1 = l1[2];
    assign col_2 = l2[1];
    assign col_3 = l3;
    assign col_4 = d_in_4;
endmodule

// File: rtl/idct_out_reorder.sv
// idct_out_reorder: deskews IDCT columns, rounds them to residuals, and emits 4x4 blocks row by row
// through a two-bank ping-pong buffer.
module idct_out_reorder
    import idct_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] d_in_1,
    input  logic [DW-1:0] d_in_2,
    input  logic [DW-1:0] d_in_3,
    input  logic [DW-1:0] d_in_4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] d_out_1,
    output logic [OW-1:0] d_out_2,
    output logic [OW-1:0] d_out_3,
    output logic [OW-1:0] d_out_4,
    output logic [1:0]    out_row,
    output logic          out_last,
    output logic          overflow
);
    logic          a_valid;
    logic [DW-1:0] a_1, a_2, a_3, a_4;
    logic [OW-1:0] rs [4];
    block_t        bank [2];
    logic          wr_bank, rd_bank;
    logic [1:0]    wr_col, rd_row, full, full_n;
    logic          rd_fire, rel, admit, wr_en;

    idct_deskew #(.W(DW)) u_deskew (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .d_in_1(d_in_1),
        .d_in_2(d_in_2),
        .d_in_3(d_in_3),
        .d_in_4(d_in_4),
        .col_valid(a_valid),
        .col_1(a_1),
        .col_2(a_2),
        .col_3(a_3),
        .col_4(a_4)
    );

    assign rs[0] = round_sat(a_1);
    assign rs[1] = round_sat(a_2);
    assign rs[2] = round_sat(a_3);
    assign rs[3] = round_sat(a_4);

    // a block start may claim the bank the reader frees this same cycle
    always_comb begin
        rd_fire = full[rd_bank] && out_ready;
        rel = rd_fire && rd_row == 2'd3;
        admit = wr_col != 2'd0 || !full[wr_bank] || (rel && rd_bank == wr_bank);
        wr_en = a_valid && admit;
        full_n = (full & ~({1'b0, rel} << rd_bank)) | ({1'b0, wr_en && wr_col == 2'd3} << wr_bank);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= '0;
            wr_bank <= 1'b0;
            wr_col <= 2'd0;
            rd_bank <= 1'b0;
            rd_row <= 2'd0;
            overflow <= 1'b0;
        end else begin
            full <= full_n;
            if (wr_en) begin
                wr_col <= wr_col + 2'd1;
                if (wr_col == 2'd3) wr_bank <= ~wr_bank;
            end
            if (a_valid && !admit) overflow <= 1'b1;
            if (rd_fire) begin
                rd_row <= rd_row + 2'd1;
                if (rd_row == 2'd3) rd_bank <= ~rd_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) for (int k = 0; k < 4; k++) bank[wr_bank][k][wr_col] <= rs[k];
    end

    assign out_valid = full[rd_bank];
    assign out_row = rd_row;
    assign out_last = rd_row == 2'd3;
    assign d_out_1 = bank[rd_bank][rd_row][0];
    assign d_out_2 = bank[rd_bank][rd_row][1];
    assign d_out_3 = bank[rd_bank][rd_row][2];
    assign d_out_4 = bank[rd_bank][rd_row][3];
endmodule
